// File: rtl/fsk2_pkg.sv
// Shared 2FSK definitions: FSM state encoding and derived timing constants,
// common to the demodulator and the DDS generator side of the link.
package fsk2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2
    } fsk2_state_t;

    // Carrier period in clocks for a given tone frequency.
    function automatic int calc_period(input int inclk, input int freq);
        return inclk / freq;
    endfunction

    function automatic int calc_thr(input int p0, input int p1);
        return (p0 + p1) / 2;
    endfunction

    function automatic int calc_spb(input int inclk, input int baud);
        return inclk / baud;
    endfunction

    function automatic int calc_loss(input int p0);
        return 2 * p0;
    endfunction

    // Vote counters stick at full scale instead of wrapping.
    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/fsk2_zero_cross.sv
// Front end of the 2FSK demodulator: sample register, hysteretic zero-level
// flag, rising-crossing pulse and per-cycle period counter.
module fsk2_zero_cross
    import fsk2_pkg::*;
#(
    parameter logic [15:0] MID  = 16'd32768,
    parameter logic [15:0] HYST = 16'd1024,
    parameter logic [7:0]  LOSS = 8'd100
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] sample_in,
    output logic        rise,
    output logic [7:0]  period,
    output logic        timeout
);

    // One extra bit keeps the band edges from wrapping near full scale.
    localparam logic [16:0] HI_LVL = {1'b0, MID} + {1'b0, HYST};
    localparam logic [16:0] LO_LVL = {1'b0, MID} - {1'b0, HYST};

    logic [15:0] s1;
    logic        hi;
    logic        hi_d;
    logic [7:0]  cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1   <= 16'd0;
            hi   <= 1'b0;
            hi_d <= 1'b0;
        end else begin
            s1 <= sample_in;
            if ({1'b0, s1} >= HI_LVL)
                hi <= 1'b1;
            else if ({1'b0, s1} <= LO_LVL)
                hi <= 1'b0;
            hi_d <= hi;
        end
    end

    assign rise = hi & ~hi_d;

    // Restarts at 1 on each crossing so the value seen at the next crossing is the full period.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt <= 8'd0;
        else if (rise)
            cnt <= 8'd1;
        else if (cnt != 8'hFF)
            cnt <= cnt + 8'd1;
    end

    assign period  = cnt;
    assign timeout = (cnt > LOSS);

endmodule

// File: rtl/fsk2_demod.sv
// 2FSK demodulator top: acquisition FSM, symbol timing, per-symbol vote and decision.
// Optional FSK2_DEMOD_CONF_EN adds bit_conf, the vote margin of each decided symbol.
module fsk2_demod
    import fsk2_pkg::*;
#(
    parameter int          INCLK_FREQ = 50_000_000,
    parameter int          F0_FREQ    = 1_000_000,
    parameter int          F1_FREQ    = 2_000_000,
    parameter int          BAUD       = 100_000,
    parameter logic [15:0] MID        = 16'd32768,
    parameter logic [15:0] HYST       = 16'd1024
)(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [15:0] sample_in,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        carrier_ok
`ifdef FSK2_DEMOD_CONF_EN
    ,
    output logic [5:0]  bit_conf
`endif
);

    localparam int         P0   = calc_period(INCLK_FREQ, F0_FREQ);
    localparam int         P1   = calc_period(INCLK_FREQ, F1_FREQ);
    localparam logic [7:0] THR  = 8'(calc_thr(P0, P1));
    localparam logic [9:0] SPB  = 10'(calc_spb(INCLK_FREQ, BAUD));
    localparam logic [7:0] LOSS = 8'(calc_loss(P0));

    logic        rise;
    logic [7:0]  period;
    logic        timeout;

    fsk2_state_t state;
    fsk2_state_t next_state;

    logic [9:0]  sym_cnt;
    logic [5:0]  votes0;
    logic [5:0]  votes1;
    logic        vote_f1;
    logic        sym_end;
    logic        track_run;
    logic        acq_lock;

    fsk2_zero_cross #(
        .MID  (MID),
        .HYST (HYST),
        .LOSS (LOSS)
    ) u_zero_cross (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .sample_in (sample_in),
        .rise      (rise),
        .period    (period),
        .timeout   (timeout)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        carrier_ok = 1'b0;
        case (state)
            IDLE: begin
                if (rise)
                    next_state = ACQ;
            end
            ACQ: begin
                if (rise && (period <= LOSS))
                    next_state = TRACK;
            end
            TRACK: begin
                carrier_ok = 1'b1;
                if (timeout)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign vote_f1   = (period < THR);
    assign track_run = (state == TRACK) && !timeout;
    assign sym_end   = track_run && (sym_cnt == SPB);
    assign acq_lock  = (state == ACQ) && (next_state == TRACK);

`ifdef FSK2_DEMOD_CONF_EN
    logic [5:0] vote_diff;
    assign vote_diff = (votes1 > votes0) ? (votes1 - votes0) : (votes0 - votes1);
`endif

    // Outside TRACK (or on loss) the partial symbol is dropped; a rise landing on
    // the wrap cycle seeds the next symbol's votes.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sym_cnt   <= 10'd0;
            votes0    <= 6'd0;
            votes1    <= 6'd0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
`ifdef FSK2_DEMOD_CONF_EN
            bit_conf  <= 6'd0;
`endif
        end else if (!track_run) begin
            sym_cnt   <= acq_lock ? 10'd1 : 10'd0;
            votes0    <= 6'd0;
            votes1    <= 6'd0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= sym_end;
            if (sym_end) begin
                sym_cnt <= 10'd1;
                votes0  <= (rise && !vote_f1) ? 6'd1 : 6'd0;
                votes1  <= (rise && vote_f1) ? 6'd1 : 6'd0;
                if (votes1 > votes0)
                    bit_out <= 1'b1;
                else if (votes0 > votes1)
                    bit_out <= 1'b0;
`ifdef FSK2_DEMOD_CONF_EN
                bit_conf <= vote_diff;
`endif
            end else begin
                sym_cnt <= sym_cnt + 10'd1;
                if (rise) begin
                    if (vote_f1)
                        votes1 <= sat_inc6(votes1);
                    else
                        votes0 <= sat_inc6(votes0);
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk2_demod.sv
// Directed self-checking bench for fsk2_demod using synthetic DDS carriers.
// Cycle numbers are counted in clock edges since the end of each reset.
module tb_fsk2_demod;

    localparam logic [15:0] MID = 16'd32768;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [15:0] sample_in;
    logic        bit_out;
    logic        bit_valid;
    logic        carrier_ok;
`ifdef FSK2_DEMOD_CONF_EN
    logic [5:0]  bit_conf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ph     = 0;

    fsk2_demod dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sample_in  (sample_in),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .carrier_ok (carrier_ok)
`ifdef FSK2_DEMOD_CONF_EN
        ,
        .bit_conf   (bit_conf)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // 50 phase steps per 1 MHz cycle; step 2 gives the 2 MHz tone.
    function automatic logic [15:0] dds_sample(input int p);
        real a;
        a = 20000.0 * $sin(6.283185307179586 * real'(p) / 50.0);
        return 16'(32768 + $rtoi(a));
    endfunction

    task automatic tick(input logic [15:0] s);
        sample_in = s;
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic carrier_tick(input int inc);
        tick(dds_sample(ph));
        ph = (ph + inc) % 50;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (3) tick(MID);
        sys_rst_n = 1'b1;
        cyc = 0;
        ph  = 0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        sample_in = MID;
        #2;
        checks++;
        if (bit_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_out: got %b expected 0", bit_out); end
        checks++;
        if (bit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_valid: got %b expected 0", bit_valid); end
        checks++;
        if (carrier_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_carrier_ok: got %b expected 0", carrier_ok); end
    endtask

    // First rise lands 3 edges after the first high sample; TRACK follows one period later.
    task automatic test_steady_carrier(input int inc, input logic exp_bit, input int track_cyc);
        int n;
        int last;
        n = 0;
        last = 0;
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            carrier_tick(inc);
            if (cyc == track_cyc - 1) begin
                checks++;
                if (carrier_ok !== 1'b0) begin errors++; $display("[TB] FAIL steady_acq_early: got %b expected 0 at cycle %0d", carrier_ok, cyc); end
            end
            if (cyc == track_cyc) begin
                checks++;
                if (carrier_ok !== 1'b1) begin errors++; $display("[TB] FAIL steady_acq: got %b expected 1 at cycle %0d", carrier_ok, cyc); end
            end
            if (bit_valid) begin
                n++;
                checks++;
                if (bit_out !== exp_bit) begin errors++; $display("[TB] FAIL steady_bit: got %b expected %b (pulse %0d)", bit_out, exp_bit, n); end
                checks++;
                if (n == 1) begin
                    if (cyc !== track_cyc + 500) begin errors++; $display("[TB] FAIL steady_first_valid: got cycle %0d expected %0d", cyc, track_cyc + 500); end
                end else if (cyc - last !== 500) begin
                    errors++; $display("[TB] FAIL steady_spacing: got %0d expected 500", cyc - last);
                end
`ifdef FSK2_DEMOD_CONF_EN
                if (n == 2) begin
                    checks++;
                    if (bit_conf !== ((inc == 2) ? 6'd20 : 6'd10)) begin
                        errors++; $display("[TB] FAIL steady_conf: got %0d expected %0d", bit_conf, (inc == 2) ? 20 : 10);
                    end
                end
`endif
                last = cyc;
            end
        end
        checks++;
        if (n < 5) begin errors++; $display("[TB] FAIL steady_count: got %0d expected at least 5", n); end
    endtask

    task automatic test_pattern();
        logic [5:0] bits;
        logic [4:0] exp;
        int n;
        bits = 6'b001101;
        exp  = 5'b01101;
        n = 0;
        do_reset();
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < 500; k++) begin
                carrier_tick(bits[s] ? 2 : 1);
                if (bit_valid) begin
                    if (n < 5) begin
                        checks++;
                        if (bit_out !== exp[n]) begin errors++; $display("[TB] FAIL pattern_bit%0d: got %b expected %b", n, bit_out, exp[n]); end
                    end
                    n++;
                end
            end
        end
        checks++;
        if (n < 5) begin errors++; $display("[TB] FAIL pattern_count: got %0d expected at least 5", n); end
    endtask

    // Last rise at edge 1154, so loss is seen at 1255; the 1554 decision must not appear.
    task automatic test_carrier_loss();
        int late_valid;
        int first_valid;
        int base;
        logic first_bit;
        late_valid = 0;
        first_valid = -1;
        first_bit = 1'b0;
        do_reset();
        for (int k = 0; k < 1800; k++) begin
            if (k < 1200) carrier_tick(1);
            else tick(MID);
            if (cyc == 1254) begin
                checks++;
                if (carrier_ok !== 1'b1) begin errors++; $display("[TB] FAIL loss_before: got %b expected 1", carrier_ok); end
            end
            if (cyc == 1255) begin
                checks++;
                if (carrier_ok !== 1'b0) begin errors++; $display("[TB] FAIL loss_drop: got %b expected 0", carrier_ok); end
            end
            if (bit_valid && cyc > 1054) late_valid++;
        end
        checks++;
        if (late_valid !== 0) begin errors++; $display("[TB] FAIL loss_partial_valid: got %0d expected 0", late_valid); end
        base = cyc;
        ph = 0;
        for (int k = 0; k < 700; k++) begin
            carrier_tick(2);
            if (bit_valid && first_valid < 0) begin
                first_valid = cyc - base;
                first_bit = bit_out;
            end
        end
        checks++;
        if (first_valid !== 529) begin errors++; $display("[TB] FAIL loss_reacq_valid: got cycle %0d expected 529", first_valid); end
        checks++;
        if (first_bit !== 1'b1) begin errors++; $display("[TB] FAIL loss_reacq_bit: got %b expected 1", first_bit); end
    endtask

    task automatic test_in_band();
        int ok_seen;
        int valid_seen;
        ok_seen = 0;
        valid_seen = 0;
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            tick(((k % 25) < 13) ? MID + 16'd800 : MID - 16'd800);
            if (carrier_ok) ok_seen++;
            if (bit_valid) valid_seen++;
        end
        checks++;
        if (ok_seen !== 0) begin errors++; $display("[TB] FAIL inband_carrier_ok: got %0d cycles expected 0", ok_seen); end
        checks++;
        if (valid_seen !== 0) begin errors++; $display("[TB] FAIL inband_valid: got %0d expected 0", valid_seen); end
    endtask

    task automatic test_reset_mid_symbol();
        int first_valid;
        logic first_bit;
        first_valid = -1;
        first_bit = 1'b0;
        do_reset();
        repeat (700) carrier_tick(2);
        checks++;
        if (bit_out !== 1'b1 || carrier_ok !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_pre: got bit_out %b carrier_ok %b expected 1 1", bit_out, carrier_ok);
        end
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({bit_out, bit_valid, carrier_ok} !== 3'b000) begin
            errors++; $display("[TB] FAIL rst_async: got %b expected 000", {bit_out, bit_valid, carrier_ok});
        end
        repeat (3) tick(MID);
        sys_rst_n = 1'b1;
        cyc = 0;
        ph  = 0;
        for (int k = 0; k < 600; k++) begin
            carrier_tick(2);
            if (cyc == 28) begin
                checks++;
                if (carrier_ok !== 1'b0) begin errors++; $display("[TB] FAIL rst_reacq_early: got %b expected 0", carrier_ok); end
            end
            if (cyc == 29) begin
                checks++;
                if (carrier_ok !== 1'b1) begin errors++; $display("[TB] FAIL rst_reacq: got %b expected 1", carrier_ok); end
            end
            if (bit_valid && first_valid < 0) begin
                first_valid = cyc;
                first_bit = bit_out;
            end
        end
        checks++;
        if (first_valid !== 529) begin errors++; $display("[TB] FAIL rst_first_valid: got cycle %0d expected 529", first_valid); end
        checks++;
        if (first_bit !== 1'b1) begin errors++; $display("[TB] FAIL rst_first_bit: got %b expected 1", first_bit); end
    endtask

    initial begin
        test_reset();
        $display("[TB] steady 1 MHz carrier");
        test_steady_carrier(1, 1'b0, 54);
        $display("[TB] steady 2 MHz carrier");
        test_steady_carrier(2, 1'b1, 29);
        $display("[TB] mixed symbol pattern");
        test_pattern();
        $display("[TB] carrier loss and restart");
        test_carrier_loss();
        $display("[TB] in-band square wave");
        test_in_band();
        $display("[TB] reset mid-symbol");
        test_reset_mid_symbol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
